result_serializer: RTL

- Downstream drain stage for the Toeplitz hash pipeline.
- Pops 3072-bit hash results from the result FIFO (write_fifo read side).
- Emits each result as 96 consecutive 32-bit beats on a valid/ready stream, so the 32-bit host/output interface can consume the wide result.
- Owns fifo rd_en generation, so nothing outside this block ties the FIFO read enable.

---
 rtl/result_serializer_if.sv | 42 ++++
 rtl/result_serializer.sv | 97 +++++++++
 2 files changed

// File: rtl/result_serializer_if.sv
// Result serializer bus bundle.
// Groups the result-FIFO read side and the narrow output stream.
//   fifo_empty  : FIFO empty flag (FIFO -> serializer)
//   fifo_dout   : FIFO read data, valid one cycle after fifo_rd_en
//   fifo_rd_en  : one-cycle FIFO pop strobe (serializer -> FIFO)
//   out_data    : current output beat
//   out_valid   : out_data is valid
//   out_ready   : consumer accepts the beat
//   out_last    : final beat of a block
// Modports: master = serializer side, slave = FIFO/consumer side.
interface result_serializer_if #(
    parameter int WIDE_W   = 3072,
    parameter int NARROW_W = 32
);
    logic                fifo_empty;
    logic [WIDE_W-1:0]   fifo_dout;
    logic                fifo_rd_en;
    logic [NARROW_W-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_last
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_last
    );
endinterface

// File: rtl/result_serializer.sv
// Result serializer: drains wide hash results from the result FIFO and
// streams each one as BEATS consecutive NARROW_W beats, LSB beat first.
// Ports:
//   clk_in    : system clock, rising edge
//   rst       : asynchronous active-high reset
//   bus       : FIFO read side + valid/ready output stream (master modport)
//   block_cnt : number of fully sent blocks, wraps
//   busy      : high whenever the FSM is not idle
//
// state | meaning
// IDLE  | waiting for a non-empty FIFO
// REQ   | fifo_rd_en asserted for this single cycle
// LOAD  | FIFO data valid, captured into the shift register
// SEND  | streaming beats; valid held until each handshake
module result_serializer #(
    parameter int WIDE_W   = 3072,
    parameter int NARROW_W = 32,
    parameter int CNT_W    = 16
) (
    input  logic                clk_in,
    input  logic                rst,
    result_serializer_if.master bus,
    output logic [CNT_W-1:0]    block_cnt,
    output logic                busy
);
    // WIDE_W must be an exact multiple of NARROW_W.
    localparam int BEATS = WIDE_W / NARROW_W;
    localparam int IDX_W = $clog2(BEATS);

    typedef enum logic [1:0] {IDLE, REQ, LOAD, SEND} state_t;

    state_t             state_q;
    logic [WIDE_W-1:0]  shift_q;
    logic [IDX_W-1:0]   beat_q;
    logic [CNT_W-1:0]   block_cnt_q;
    logic               rd_en_q;
    logic               valid_q;
    logic               last_beat;
    logic               handshake;

    // Gated by SEND so out_last never shows outside a block.
    assign last_beat = (state_q == SEND) && (beat_q == IDX_W'(BEATS - 1));
    assign handshake = valid_q && bus.out_ready;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            beat_q      <= '0;
            block_cnt_q <= '0;
            rd_en_q     <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.fifo_empty) begin
                        rd_en_q <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    rd_en_q <= 1'b0;
                    state_q <= LOAD;
                end
                LOAD: begin
                    shift_q <= bus.fifo_dout;
                    beat_q  <= '0;
                    valid_q <= 1'b1;
                    state_q <= SEND;
                end
                SEND: begin
                    if (handshake) begin
                        shift_q <= shift_q >> NARROW_W;
                        if (last_beat) begin
                            beat_q      <= '0;
                            valid_q     <= 1'b0;
                            block_cnt_q <= block_cnt_q + CNT_W'(1);
                            state_q     <= IDLE;
                        end else begin
                            beat_q <= beat_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.fifo_rd_en = rd_en_q;
    assign bus.out_data   = shift_q[NARROW_W-1:0];
    assign bus.out_valid  = valid_q;
    assign bus.out_last   = last_beat;
    assign block_cnt      = block_cnt_q;
    assign busy           = (state_q != IDLE);
endmodule
